// File: rtl/bounce_squares_pkg.sv
// bounce_squares_pkg: shared colour-state encoding, background level and
// default raster size for the bouncing-squares display block.
package bounce_squares_pkg;

   typedef enum logic [1:0] {
      CST_IDLE  = 2'd0,
      CST_RED   = 2'd1,
      CST_GREEN = 2'd2,
      CST_BLUE  = 2'd3
   } color_st_e;

   localparam int DEF_H_RES = 640;
   localparam int DEF_V_RES = 480;
   localparam int BG_LEVEL  = 2;

   // One step of the colour cycle: IDLE->RED->GREEN->BLUE->RED.
   function automatic color_st_e color_step(input color_st_e st);
      color_st_e nxt;
      case (st)
         CST_IDLE:  nxt = CST_RED;
         CST_RED:   nxt = CST_GREEN;
         CST_GREEN: nxt = CST_BLUE;
         CST_BLUE:  nxt = CST_RED;
         default:   nxt = CST_IDLE;
      endcase
      return nxt;
   endfunction

   // Colour of square idx (0..3): idx extra steps ahead; IDLE stays IDLE.
   function automatic color_st_e color_offset(input color_st_e st, input int idx);
      color_st_e cur;
      cur = st;
      if (st != CST_IDLE) begin
         for (int k = 0; k < 3; k++) begin
            if (k < idx) cur = color_step(cur);
            else         cur = cur;
         end
      end else begin
         cur = CST_IDLE;
      end
      return cur;
   endfunction

endpackage

// File: rtl/bounce_squares_axis.sv
// bounce_axis: position and direction of one square along one axis.
// Moves by speed on each frame tick and bounces off 0 and LIMIT-1-size.
// Edge sums are formed one bit wider than the coordinate so nothing wraps.
module bounce_axis
   import bounce_squares_pkg::*;
#(
   parameter int COORD_W   = 10,
   parameter int LIMIT     = DEF_H_RES,
   parameter int RESET_POS = 0,
   parameter bit RESET_DIR = 1'b1
) (
   input  logic               clck_i,
   input  logic               reset_i,
   input  logic               tick_i,
   input  logic [COORD_W-1:0] size_i,
   input  logic [3:0]         speed_i,
   output logic [COORD_W-1:0] pos_o
);

   localparam logic [COORD_W:0] LIM_M1 = (COORD_W+1)'(LIMIT - 1);

   logic [COORD_W-1:0] pos_q, pos_d;
   logic               dir_q, dir_d;
   logic [COORD_W:0]   pos_w, size_w, speed_w, reach_w;

   // Next position/direction for the coming tick.
   always_comb begin
      pos_w   = {1'b0, pos_q};
      size_w  = {1'b0, size_i};
      speed_w = (COORD_W+1)'(speed_i);
      reach_w = pos_w + size_w + speed_w;
      if (dir_q) begin
         if (reach_w > LIM_M1) begin
            pos_d = COORD_W'(LIM_M1 - size_w);
            dir_d = 1'b0;
         end else begin
            pos_d = COORD_W'(pos_w + speed_w);
            dir_d = 1'b1;
         end
      end else begin
         if (pos_w < speed_w) begin
            pos_d = COORD_W'(0);
            dir_d = 1'b1;
         end else begin
            pos_d = COORD_W'(pos_w - speed_w);
            dir_d = 1'b0;
         end
      end
   end

   // Axis state: reset wins over a coincident tick, otherwise move on tick.
   always_ff @(posedge clck_i) begin
      if (reset_i) begin
         pos_q <= COORD_W'(RESET_POS);
         dir_q <= RESET_DIR;
      end else if (tick_i) begin
         pos_q <= pos_d;
         dir_q <= dir_d;
      end else begin
         pos_q <= pos_q;
         dir_q <= dir_q;
      end
   end

   assign pos_o = pos_q;

endmodule

// File: rtl/bounce_squares.sv
// bounce_squares: N_SQUARES squares bouncing around the visible raster,
// each cycling through red/green/blue one step apart. Pixel colour is
// registered one clock after the raster coordinates.
// Optional feature: define BOUNCE_SQUARES_OUTLINE_EN to draw every square's
// 1-pixel perimeter white; otherwise squares are solid-filled.
module bounce_squares
   import bounce_squares_pkg::*;
#(
   parameter int N_SQUARES = 2,
   parameter int COORD_W   = 10,
   parameter int COLOR_W   = 4,
   parameter int H_RES     = DEF_H_RES,
   parameter int V_RES     = DEF_V_RES
) (
   input  logic               clck,
   input  logic               reset,
   input  logic [COORD_W-1:0] x_coords,
   input  logic [COORD_W-1:0] y_coords,
   input  logic [17:0]        switches,
   output logic [COLOR_W-1:0] red,
   output logic [COLOR_W-1:0] green,
   output logic [COLOR_W-1:0] blue
);

   localparam logic [COLOR_W-1:0] C_MAX  = {COLOR_W{1'b1}};
   localparam logic [COLOR_W-1:0] C_ZERO = {COLOR_W{1'b0}};
   localparam logic [COLOR_W-1:0] C_BG   = COLOR_W'(BG_LEVEL);
   localparam logic [9:0]         SIZE_MAX_SW = 10'(V_RES - 1);

   function automatic logic [3*COLOR_W-1:0] rgb_of(input color_st_e st);
      logic [3*COLOR_W-1:0] rgb;
      case (st)
         CST_RED:   rgb = {C_MAX,  C_ZERO, C_ZERO};
         CST_GREEN: rgb = {C_ZERO, C_MAX,  C_ZERO};
         CST_BLUE:  rgb = {C_ZERO, C_ZERO, C_MAX};
         default:   rgb = {C_MAX,  C_MAX,  C_MAX};   // IDLE shows white
      endcase
      return rgb;
   endfunction

   logic                              tick_cond_s, tick_seen_q, frame_tick_s;
   logic [COORD_W-1:0]                size_s, size_q;
   logic [3:0]                        speed_s;
   logic [2:0]                        unused_sw_s;
   color_st_e                         state_q;
   logic [N_SQUARES-1:0][COORD_W-1:0] sq_x_s, sq_y_s;
   logic [3*COLOR_W-1:0]              pix_d;
   logic [COORD_W:0]                  px_s, py_s, x_lo_s, x_hi_s, y_lo_s, y_hi_s;
`ifdef BOUNCE_SQUARES_OUTLINE_EN
   logic                              edge_hit_s;
`endif

   assign unused_sw_s = switches[12:10];
   assign speed_s     = switches[16:13];

   // Tick detection and size clamping from the switches.
   always_comb begin
      tick_cond_s  = (x_coords == COORD_W'(0)) && (y_coords == COORD_W'(V_RES));
      frame_tick_s = tick_cond_s && !tick_seen_q;
      if (switches[9:0] > SIZE_MAX_SW) size_s = COORD_W'(SIZE_MAX_SW);
      else                             size_s = COORD_W'(switches[9:0]);
   end

   // Only the first cycle of the tick condition counts; size used for drawing is latched on tick.
   always_ff @(posedge clck) begin
      if (reset) begin
         tick_seen_q <= 1'b0;
         size_q      <= COORD_W'(0);
      end else begin
         tick_seen_q <= tick_cond_s;
         if (frame_tick_s) size_q <= size_s;
         else              size_q <= size_q;
      end
   end

   // Colour state machine, advanced once per frame tick; SW17 forces IDLE.
   always_ff @(posedge clck) begin
      if (reset) begin
         state_q <= CST_IDLE;
      end else if (frame_tick_s) begin
         if (switches[17]) state_q <= CST_IDLE;
         else              state_q <= color_step(state_q);
      end else begin
         state_q <= state_q;
      end
   end

   for (genvar gi = 0; gi < N_SQUARES; gi++) begin : g_sq
      bounce_axis #(
         .COORD_W  (COORD_W),
         .LIMIT    (H_RES),
         .RESET_POS(gi * (H_RES / N_SQUARES)),
         .RESET_DIR(1'b1)
      ) u_axis_x (
         .clck_i (clck),
         .reset_i(reset),
         .tick_i (frame_tick_s),
         .size_i (size_s),
         .speed_i(speed_s),
         .pos_o  (sq_x_s[gi])
      );
      bounce_axis #(
         .COORD_W  (COORD_W),
         .LIMIT    (V_RES),
         .RESET_POS(gi * 32),
         .RESET_DIR((gi % 2) == 0)
      ) u_axis_y (
         .clck_i (clck),
         .reset_i(reset),
         .tick_i (frame_tick_s),
         .size_i (size_s),
         .speed_i(speed_s),
         .pos_o  (sq_y_s[gi])
      );
   end

   // Pixel colour: scan from highest to lowest index so square 0 wins overlaps.
   always_comb begin
      pix_d  = {C_BG, C_BG, C_BG};
      px_s   = {1'b0, x_coords};
      py_s   = {1'b0, y_coords};
      x_lo_s = '0;
      x_hi_s = '0;
      y_lo_s = '0;
      y_hi_s = '0;
`ifdef BOUNCE_SQUARES_OUTLINE_EN
      edge_hit_s = 1'b0;
`endif
      for (int i = N_SQUARES - 1; i >= 0; i--) begin
         x_lo_s = {1'b0, sq_x_s[i]};
         y_lo_s = {1'b0, sq_y_s[i]};
         x_hi_s = x_lo_s + {1'b0, size_q};
         y_hi_s = y_lo_s + {1'b0, size_q};
         if (px_s >= x_lo_s && px_s <= x_hi_s && py_s >= y_lo_s && py_s <= y_hi_s) begin
            pix_d = rgb_of(color_offset(state_q, i));
`ifdef BOUNCE_SQUARES_OUTLINE_EN
            if (px_s == x_lo_s || px_s == x_hi_s || py_s == y_lo_s || py_s == y_hi_s)
               edge_hit_s = 1'b1;
            else
               edge_hit_s = edge_hit_s;
`endif
         end else begin
            pix_d = pix_d;
         end
      end
`ifdef BOUNCE_SQUARES_OUTLINE_EN
      if (edge_hit_s) pix_d = {C_MAX, C_MAX, C_MAX};
      else            pix_d = pix_d;
`endif
   end

   // Registered colour outputs, one clock after the coordinates.
   always_ff @(posedge clck) begin
      if (reset) begin
         red   <= C_ZERO;
         green <= C_ZERO;
         blue  <= C_ZERO;
      end else begin
         red   <= pix_d[3*COLOR_W-1 -: COLOR_W];
         green <= pix_d[2*COLOR_W-1 -: COLOR_W];
         blue  <= pix_d[COLOR_W-1 -: COLOR_W];
      end
   end

endmodule

// File: doc/bounce_squares.md
BOUNCE_SQUARES -- requirements
Module: bounce_squares

Interface
REQ-001 SHALL have parameter N_SQUARES, default 2, number of independent squares (1..4).
REQ-002 SHALL have parameter COORD_W, default 10, raster coordinate width.
REQ-003 SHALL have parameter COLOR_W, default 4, per-channel colour width.
REQ-004 SHALL have parameters H_RES, default 640, and V_RES, default 480, visible raster size.
REQ-005 SHALL have port clck, input, 1, single pixel clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 SHALL have ports x_coords and y_coords, input, COORD_W each, current raster position.
REQ-008 SHALL have port switches, input, 18: SW17 colour reset, SW16..13 speed, SW9..0 size.
REQ-009 SHALL have ports red, green and blue, output, COLOR_W each, registered pixel colour.

Function
REQ-010 SHALL generate a one-cycle frame_tick on the first clck where x_coords==0 and y_coords==V_RES; at most one tick per frame.
REQ-011 SHALL update square positions, directions and colour state only on frame_tick.
REQ-012 SHALL clamp size = min(SW9..0, V_RES-1) and speed = SW16..13 (0..15), both sampled at frame_tick.
REQ-013 SHALL track per square x, y (COORD_W) and direction bits dx, dy (1 = increasing).
REQ-014 SHALL compute edge tests at COORD_W+1 bits so that no sum wraps.
REQ-015 SHALL, per axis with dir=1, set pos to LIMIT-1-size and dir to 0 when pos+size+speed > LIMIT-1; otherwise pos += speed.
REQ-016 SHALL, per axis with dir=0, set pos to 0 and dir to 1 when pos < speed; otherwise pos -= speed.
REQ-017 SHALL use LIMIT = H_RES for x and V_RES for y; speed 0 leaves a square stationary.
REQ-018 SHALL implement colour FSM states IDLE, RED, GREEN, BLUE: IDLE->RED->GREEN->BLUE->RED per tick; SW17=1 at tick forces IDLE.
REQ-019 SHALL give square i the colour reached from the FSM state by i extra RED/GREEN/BLUE steps; in IDLE every square is white.
REQ-020 SHALL treat a pixel as inside square i when x<=x_coords<=x+size and y<=y_coords<=y+size.
REQ-021 SHALL give the lowest square index priority where squares overlap.
REQ-022 SHALL output background 2 on every channel when no square covers the pixel.
REQ-023 SHALL register red, green and blue with a latency of exactly 1 clck from the coordinates.

Reset
REQ-024 SHALL, on reset, set square i to x=i*(H_RES/N_SQUARES), y=i*32, dx=1, dy=(i even).
REQ-025 SHALL, on reset, set the FSM to IDLE, clear frame_tick state and drive red/green/blue=0 on the next edge.
REQ-026 SHALL let reset override a coincident frame_tick; the first movement occurs at the first tick after reset is released.

Configuration
REQ-027 SHALL, with BOUNCE_SQUARES_OUTLINE_EN defined, draw the 1-pixel perimeter of every square white regardless of colour state.
REQ-028 SHALL, without BOUNCE_SQUARES_OUTLINE_EN, fill squares with their solid state colour.

Structure
REQ-029 SHALL define the colour-state encoding, the background constant and the default H_RES/V_RES in shared package bounce_squares_pkg.
REQ-030 SHALL implement single-axis position/direction update (REQ-015..016) as sub-module bounce_axis, instantiated 2*N_SQUARES times.

Verification
REQ-031 SHALL cover: reset, then raster at (0,0) with square 0 at (0,0), IDLE state -> output 15/15/15 after 1 clck.
REQ-032 SHALL cover: size 10, speed 4, x=626, dx=1, tick -> x=629, dx=0; next tick -> x=625.
REQ-033 SHALL cover: x=3, dx=0, speed 4, tick -> x=0, dx=1; speed 0 over 3 ticks -> position unchanged.
REQ-034 SHALL cover: SW17=0 over 4 ticks -> square 0 colours RED, GREEN, BLUE, RED with square 1 one step ahead; SW17=1 -> all white.
REQ-035 SHALL cover: squares 0 and 1 overlapping at a pixel -> square 0 colour; uncovered pixel -> 2/2/2; SW9..0=1023 -> size 479.
REQ-036 SHALL cover: with the macro defined, a pixel on a square edge -> white and an interior pixel -> state colour.
